// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage CPU pipeline: default datapath width,
// the NOP encoding used for bubbles, and the sequential PC increment.
package cpu_pkg;

  localparam int          WIDTH_DEF     = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam int          PC_STEP       = 4;

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; clear beats increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall (hold), flush (NOP bubble) and run-enable freeze.
// Optional stall/flush performance counters are built only when IFID_PERF_CNT_EN is defined.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int               CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IFIDWrite_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [WIDTH-1:0] instr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [WIDTH-1:0] instr_q,    instr_d;
  logic             valid_q,    valid_d;

  // Priority below reset: flush squashes, then stall holds, then start gates capture.
  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (flush_i) begin
      pc_d       = '0;
      pc_plus4_d = '0;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
    end else if (IFIDWrite_i && start_i) begin
      pc_d       = pc_i;
      pc_plus4_d = pc_i + WIDTH'(PC_STEP);
      instr_d    = instr_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

`ifdef IFID_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // A stall cycle is one where the CPU is running but the hazard unit blocks the write.
  assign stall_inc = !flush_i && start_i && !IFIDWrite_i;
  assign flush_inc = flush_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Randomized bench for if_id_reg against a cycle-level reference model; a second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        rst_i, start_i, IFIDWrite_i, flush_i;
  logic [31:0] pc_i, instr_i;
  logic [31:0] pc_o, pc_plus4_o, instr_o;
  logic        valid_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [31:0] pc_s, pc4_s, instr_s;
  logic        valid_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (unbounded event counts, saturation applied at compare)
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  longint      m_stalls, m_flushes;

  always #5 clk = ~clk;

  if_id_reg #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .IFIDWrite_i(IFIDWrite_i),
    .flush_i(flush_i), .pc_i(pc_i), .instr_i(instr_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o), .valid_o(valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_id_reg #(.CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .IFIDWrite_i(IFIDWrite_i),
    .flush_i(flush_i), .pc_i(pc_i), .instr_i(instr_i),
    .pc_o(pc_s), .pc_plus4_o(pc4_s), .instr_o(instr_s), .valid_o(valid_s),
    .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint lim;
    lim = (longint'(1) << bits) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_pc = 0; m_pc4 = 0; m_instr = 32'h0; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else if (flush_i) begin
      m_pc = 0; m_pc4 = 0; m_instr = 32'h0; m_valid = 1'b0;
      m_flushes++;
    end else if (!IFIDWrite_i) begin
      if (start_i) m_stalls++;
    end else if (start_i) begin
      m_pc    = pc_i;
      m_pc4   = 32'((longint'(pc_i) + 4) % (longint'(1) << 32));
      m_instr = instr_i;
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    longint es, ef, ess, efs;
`ifdef IFID_PERF_CNT_EN
    es = sat(m_stalls, 32); ef = sat(m_flushes, 32);
    ess = sat(m_stalls, 2); efs = sat(m_flushes, 2);
`else
    es = 0; ef = 0; ess = 0; efs = 0;
`endif
    check({tag, ".pc"},        64'(pc_o),        64'(m_pc));
    check({tag, ".pc4"},       64'(pc_plus4_o),  64'(m_pc4));
    check({tag, ".instr"},     64'(instr_o),     64'(m_instr));
    check({tag, ".valid"},     64'(valid_o),     64'(m_valid));
    check({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(es));
    check({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(ef));
    check({tag, ".s_pc"},      64'(pc_s),        64'(m_pc));
    check({tag, ".s_valid"},   64'(valid_s),     64'(m_valid));
    check({tag, ".s_stall"},   64'(stall_cnt_s), 64'(ess));
    check({tag, ".s_flush"},   64'(flush_cnt_s), 64'(efs));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;
    rst_i = 1'b1; start_i = 1'b0; IFIDWrite_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h40; instr_i = 32'h2001_0005;
    #2;
    step("reset0");
    step("reset1");

    rst_i = 1'b0; start_i = 1'b1; IFIDWrite_i = 1'b1;
    pc_i = 32'h8; instr_i = 32'h0220_8020;
    step("capture");
    check("capture.pc4_abs", 64'(pc_plus4_o), 64'h0000_000C);

    IFIDWrite_i = 1'b0; pc_i = 32'hC;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.instr_abs", 64'(instr_o), 64'h0220_8020);

    flush_i = 1'b1;
    step("flush_over_stall");
    flush_i = 1'b0;

    IFIDWrite_i = 1'b1; pc_i = 32'hFFFF_FFFC; instr_i = 32'h1234_5678;
    step("wrap");
    check("wrap.pc4_abs", 64'(pc_plus4_o), 64'h0);

    start_i = 1'b0; pc_i = 32'h100; instr_i = 32'hDEAD_BEEF;
    step("freeze");

    rst_i = 1'b1; step("reset_mid");
    rst_i = 1'b0; start_i = 1'b1; IFIDWrite_i = 1'b0;
    for (int i = 0; i < 5; i++) step("sat_stall");

    for (int i = 0; i < 400; i++) begin
      rst_i       = ($urandom_range(0, 99) < 3);
      flush_i     = ($urandom_range(0, 99) < 12);
      IFIDWrite_i = ($urandom_range(0, 99) >= 25);
      start_i     = ($urandom_range(0, 99) >= 10);
      pc_i        = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      instr_i     = $urandom();
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
